// File: rtl/rv32i_types.sv
// ============================================================================
// Module   : rv32i_types
// Brief    : Shared pipeline type definitions (skid-stage state encoding).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_skid_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; cleared only by reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Valid/ready pipeline register, optional two-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
    import rv32i_types::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_skid_state_t r_state;
    pipe_skid_state_t w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_drain;
    logic             w_stall_inc;

    assign w_accept    = in_valid & w_in_ready;
    assign w_drain     = out_valid & out_ready;
    assign w_stall_inc = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Flush wins over everything; an accept in the flush cycle is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        if (SKID != 0) begin
                            w_state_nxt = TWO;
                            w_skid_nxt  = in_data;
                        end
                    end else if (w_drain) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_drain) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Ready comes straight from a flop so out_ready never reaches in_ready.
            logic r_in_ready;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != TWO);
                end
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_in_ready = (r_state == EMPTY) | out_ready;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign occupancy = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Self-checking bench for pipe_skid_reg (SKID=1 and SKID=0 copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, flush;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;
    logic [2:0] stall_cnt;

    logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_flush;
    logic [7:0]  z_in_data, z_out_data;
    logic [1:0]  z_occupancy;
    logic [15:0] z_stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_data;
        logic [1:0] e_occ;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(8), .SKID(1), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_reg #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (z_in_valid),
        .in_data   (z_in_data),
        .in_ready  (z_in_ready),
        .out_valid (z_out_valid),
        .out_data  (z_out_data),
        .out_ready (z_out_ready),
        .flush     (z_flush),
        .occupancy (z_occupancy),
        .stall_cnt (z_stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accept, pop and compare on drain, drop on flush/reset.
    always @(posedge clk) begin
        if (!rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb1_underflow: got=%0h expected=none", out_data);
                end else begin
                    chk("sb1_data", {24'd0, out_data}, {24'd0, q1.pop_front()});
                end
            end
            if (flush) q1.delete();
            else if (in_valid && in_ready) q1.push_back(in_data);

            if (z_out_valid && z_out_ready) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb0_underflow: got=%0h expected=none", z_out_data);
                end else begin
                    chk("sb0_data", {24'd0, z_out_data}, {24'd0, q0.pop_front()});
                end
            end
            if (z_flush) q0.delete();
            else if (z_in_valid && z_in_ready) q0.push_back(z_in_data);
        end
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0; z_flush = 1'b0;

        // Backpressure: 0xA/0xB held, 0xC refused while full, then in order.
        tbl[0] = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd1};
        tbl[2] = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
        tbl[3] = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
        tbl[4] = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0A, 2'd2};
        tbl[5] = '{1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 8'h0B, 2'd1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0C, 2'd1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst0_in_ready", z_in_ready, 1);
        chk("rst0_out_valid", z_out_valid, 0);
        chk("rst0_stall", z_stall_cnt, 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("bp%0d_rdy", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("bp%0d_ov", i), out_valid, tbl[i].e_ov);
            chk($sformatf("bp%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("bp%0d_occ", i), occupancy, tbl[i].e_occ);
            step();
        end
        chk("bp_stall", stall_cnt, 3);

        // Flush at occupancy 2 with an input offered: 0xD must vanish.
        in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h21; step();
        in_data = 8'h22; step();
        chk("fl_occ_full", occupancy, 2);
        in_data = 8'h0D; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", occupancy, 0);
        chk("fl_ov", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fl_idle%0d_ov", i), out_valid, 0);
            step();
        end

        // Flush coinciding with a drain: the drained payload is not re-presented.
        in_valid = 1'b1; in_data = 8'h31; out_ready = 1'b0; step();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0;
        chk("fld_ov", out_valid, 0);
        chk("fld_occ", occupancy, 0);

        // Streaming 0x11..0x18 at full rate.
        for (int i = 0; i < 10; i++) begin
            in_valid  = (i < 8);
            in_data   = 8'h11 + 8'(i);
            out_ready = 1'b1;
            #1;
            chk($sformatf("st%0d_rdy", i), in_ready, 1);
            if (i == 0) begin
                chk("st0_ov", out_valid, 0);
            end else if (i <= 8) begin
                chk($sformatf("st%0d_ov", i), out_valid, 1);
                chk($sformatf("st%0d_data", i), out_data, 8'h11 + 8'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;

        // Stall counter saturation at 7 (CNT_W=3).
        rst = 1'b0; step(); rst = 1'b1;
        chk("sat_clear", stall_cnt, 0);
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0; step();
        in_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            chk($sformatf("sat%0d", k), stall_cnt, (k < 7) ? k : 7);
            step();
        end
        out_ready = 1'b1; step();

        // Asynchronous reset while holding two entries.
        in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h41; step();
        in_data = 8'h42; step();
        in_valid = 1'b0;
        chk("ar_occ_full", occupancy, 2);
        #3 rst = 1'b0;
        #1;
        chk("ar_ov", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_rdy", in_ready, 1);
        chk("ar_data", out_data, 0);
        chk("ar_stall", stall_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_post_ov", out_valid, 0);

        // SKID=0: ready follows out_ready combinationally while full.
        z_in_valid = 1'b1; z_in_data = 8'h61; z_out_ready = 1'b0; step();
        z_in_data = 8'h62;
        #1;
        chk("z_rdy_blocked", z_in_ready, 0);
        chk("z_ov", z_out_valid, 1);
        z_out_ready = 1'b1;
        #1;
        chk("z_rdy_same_cycle", z_in_ready, 1);
        step();
        z_in_valid = 1'b0; step();

        for (int i = 0; i < 400; i++) begin
            z_in_valid  = 1'($urandom_range(0, 1));
            z_out_ready = ($urandom_range(0, 3) != 0);
            z_in_data   = 8'($urandom);
            #1;
            chk("z_rnd_rdy", z_in_ready, (!z_out_valid) | z_out_ready);
            chk("z_rnd_occ_le1", (z_occupancy <= 2'd1), 1);
            step();
        end
        z_in_valid = 1'b0; z_out_ready = 1'b1;
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (3) step();
        chk("z_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
